add_share_rr: RTL and testbench

- Round-robin scheduler that time-shares one LEN-bit adder (A + B + carry-in, carry-out, signed overflow) between N requesters.
- Adds a lock mode so one requester can stream consecutive words through the adder, with the carry chained internally, to build wide multi-word additions.
- Sits between several client datapaths and a single shared adder slice, so the adder logic is not duplicated per client.

---
 rtl/add_share_rr.sv | 147 ++++++++++++++
 tb/tb_add_share_rr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_rr.sv
// Round-robin scheduler sharing one LEN-bit adder among N requesters.
// A lock lets the current owner stream words through the adder with the carry chained internally.
module add_share_rr #(
    parameter int LEN = 16,
    parameter int N   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     lock,
    input  logic [N*LEN-1:0] A,
    input  logic [N*LEN-1:0] B,
    input  logic [N-1:0]     IC,
    output logic [N-1:0]     gnt,
    output logic [LEN-1:0]   Y,
    output logic             OC,
    output logic             OVF,
    output logic [N-1:0]     ack,
    output logic             busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StLock} mode_e;

    mode_e          mode_q, mode_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic           cr_q, cr_d;
    logic [LEN-1:0] y_q, y_d;
    logic           oc_q, oc_d;
    logic           ovf_q, ovf_d;
    logic [N-1:0]   ack_q, ack_d;
    logic           busy_q, busy_d;

    logic           lock_held, released;
    logic           win_vld;
    logic [IW-1:0]  win_idx, cand, ptr_nxt;
    logic [N-1:0]   win_oh;
    logic [LEN-1:0] a_w, b_w;
    logic           cin, ovf;
    logic [LEN:0]   sum;

    assign lock_held = (mode_q == StLock) && req[owner_q];
    assign released  = (mode_q == StLock) && !req[owner_q];

    // Descending scan so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (lock_held) begin
            win_vld = 1'b1;
            win_idx = owner_q;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = IW'((int'(ptr_q) + k) % N);
                if (req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            win_oh[i] = win_vld && (win_idx == IW'(i));
        end
    end

    assign a_w     = A[win_idx*LEN +: LEN];
    assign b_w     = B[win_idx*LEN +: LEN];
    assign cin     = lock_held ? cr_q : IC[win_idx];
    assign sum     = {1'b0, a_w} + {1'b0, b_w} + {{LEN{1'b0}}, cin};
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf     = (a_w[LEN-1] == b_w[LEN-1]) && (sum[LEN-1] != a_w[LEN-1]);
    assign ptr_nxt = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            cr_q    <= 1'b0;
            y_q     <= '0;
            oc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cr_q    <= cr_d;
            y_q     <= y_d;
            oc_q    <= oc_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cr_d    = cr_q;
        y_d     = y_q;
        oc_d    = oc_q;
        ovf_d   = ovf_q;
        ack_d   = '0;
        busy_d  = busy_q;
        if (win_vld) begin
            y_d   = sum[LEN-1:0];
            oc_d  = sum[LEN];
            ovf_d = ovf;
            ack_d = win_oh;
            if (lock[win_idx]) begin
                mode_d  = StLock;
                owner_d = win_idx;
                cr_d    = sum[LEN];
                busy_d  = 1'b1;
            end else begin
                mode_d = StIdle;
                ptr_d  = ptr_nxt;
                cr_d   = 1'b0;
                busy_d = 1'b0;
            end
        end else if (released) begin
            mode_d = StIdle;
            cr_d   = 1'b0;
            busy_d = 1'b0;
        end
    end

    always_comb begin
        gnt = rst ? '0 : win_oh;
    end

    assign Y    = y_q;
    assign OC   = oc_q;
    assign OVF  = ovf_q;
    assign ack  = ack_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_add_share_rr.sv
// Scoreboard bench for add_share_rr: a behavioural model predicts grants and results,
// a negedge monitor pops expected results whenever ack is presented.
module tb_add_share_rr;

    localparam int LEN = 16;
    localparam int N   = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req, lock, IC;
    logic [N*LEN-1:0] A, B;
    logic [N-1:0]     gnt, ack;
    logic [LEN-1:0]   Y;
    logic             OC, OVF, busy;

    add_share_rr #(.LEN(LEN), .N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (lock),
        .A    (A),
        .B    (B),
        .IC   (IC),
        .gnt  (gnt),
        .Y    (Y),
        .OC   (OC),
        .OVF  (OVF),
        .ack  (ack),
        .busy (busy)
    );

    typedef struct {
        logic [N-1:0]   ack;
        logic [LEN-1:0] y;
        logic           oc;
        logic           ovf;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Model state: owner of a held lock (-1 = none), round-robin pointer, chained carry.
    int   m_owner = -1;
    int   m_ptr = 0;
    bit   m_cr = 0;
    bit   m_known = 0;
    bit   m_was_rst = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (ack !== '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack=%b with no result pending", ack);
            end else begin
                e = q.pop_front();
                if (ack !== e.ack || Y !== e.y || OC !== e.oc || OVF !== e.ovf || cyc != e.cyc + 1) begin
                    errors++;
                    $display("FAIL result: got ack=%b Y=%h OC=%b OVF=%b cyc=%0d, want ack=%b Y=%h OC=%b OVF=%b cyc=%0d",
                             ack, Y, OC, OVF, cyc, e.ack, e.y, e.oc, e.ovf, e.cyc + 1);
                end
            end
        end else if (q.size() > 0 && q[0].cyc + 1 <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_ack: got ack=0 at cyc=%0d, want ack=%b", cyc, q[0].ack);
            void'(q.pop_front());
        end
    end

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [N*LEN-1:0] a, input logic [N*LEN-1:0] b,
                         input logic [N-1:0] ic, input logic rs);
        int             w;
        bit             chained;
        bit             cin;
        int unsigned    u;
        int             sv, sa, sb;
        logic [LEN-1:0] av, bv;
        logic [N-1:0]   exp_gnt;
        exp_t           e;
        @(posedge clk);
        #1;
        if (m_known) begin
            checks++;
            if (busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL busy: got %b, want %b", busy, m_owner >= 0);
            end
        end
        if (m_was_rst && !rs) begin
            checks++;
            if (Y !== '0 || OC !== 1'b0 || OVF !== 1'b0 || ack !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got Y=%h OC=%b OVF=%b ack=%b, want all zero",
                         Y, OC, OVF, ack);
            end
        end
        req = r; lock = l; A = a; B = b; IC = ic; rst = rs;

        w = -1;
        chained = 0;
        if (m_owner >= 0 && r[m_owner]) begin
            w = m_owner;
            chained = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        exp_gnt = (rs || w < 0) ? '0 : N'(1) << w;

        #1;
        if (m_known || rs) begin
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL gnt: got %b, want %b (req=%b)", gnt, exp_gnt, r);
            end
        end

        if (rs) begin
            m_owner = -1; m_ptr = 0; m_cr = 0; m_known = 1; m_was_rst = 1;
        end else begin
            m_was_rst = 0;
            if (w >= 0) begin
                av  = a[w*LEN +: LEN];
                bv  = b[w*LEN +: LEN];
                cin = chained ? m_cr : ic[w];
                u   = int'(av) + int'(bv) + int'(cin);
                sa  = $signed(av);
                sb  = $signed(bv);
                sv  = sa + sb + int'(cin);
                e.ack = N'(1) << w;
                e.y   = u[LEN-1:0];
                e.oc  = u[LEN];
                e.ovf = (sv > 2**(LEN-1) - 1) || (sv < -(2**(LEN-1)));
                e.cyc = cyc;
                q.push_back(e);
                if (l[w]) begin
                    m_owner = w;
                    m_cr = e.oc;
                end else begin
                    m_owner = -1;
                    m_ptr = (w + 1) % N;
                end
            end else if (m_owner >= 0) begin
                m_owner = -1;
            end
        end
    endtask

    function automatic logic [N*LEN-1:0] slot(input int i, input logic [LEN-1:0] v);
        logic [N*LEN-1:0] p;
        p = '0;
        p[i*LEN +: LEN] = v;
        return p;
    endfunction

    initial begin
        logic [N*LEN-1:0] ra, rb;
        rst = 1'b1; req = '0; lock = '0; A = '0; B = '0; IC = '0;

        // Reset with all requests asserted
        cycle(4'b1111, 4'b0000, '0, '0, '0, 1'b1);
        cycle(4'b1111, 4'b0000, '0, '0, '0, 1'b1);
        // Single op with signed overflow
        cycle(4'b0001, 4'b0000, slot(0, 16'h7FFF), slot(0, 16'h0001), 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, '0, 1'b0);
        // Round robin
        for (int i = 0; i < 5; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            cycle(4'b1111, 4'b0000, ra, rb, 4'($urandom), 1'b0);
        end
        cycle(4'b0000, 4'b0000, '0, '0, '0, 1'b0);
        // Chained burst by requester 1, then fairness skip to 3
        cycle(4'b0010, 4'b0010, slot(1, 16'hFFFF), slot(1, 16'h0001), 4'b0000, 1'b0);
        cycle(4'b1010, 4'b0000, slot(3, 16'h1234), slot(3, 16'h1111), 4'b0000, 1'b0);
        cycle(4'b1001, 4'b0000, slot(3, 16'h8000), slot(3, 16'h8000), 4'b0000, 1'b0);
        // Lock released by dropping req
        cycle(4'b0001, 4'b0001, slot(0, 16'hFFFF), slot(0, 16'h0001), 4'b0000, 1'b0);
        cycle(4'b0100, 4'b0000, slot(2, 16'h0001), slot(2, 16'h0001), 4'b0100, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, '0, 1'b0);
        // Reset mid-lock discards the chained carry
        cycle(4'b0010, 4'b0010, slot(1, 16'hFFFF), slot(1, 16'h0001), 4'b0000, 1'b0);
        cycle(4'b0010, 4'b0010, '0, '0, '0, 1'b1);
        cycle(4'b0010, 4'b0000, '0, '0, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, '0, 1'b0);

        // Random traffic with edge-case operands and occasional resets
        for (int i = 0; i < 1500; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, N-1)*LEN +: LEN] = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, N-1)*LEN +: LEN] = 16'h7FFF;
            cycle(4'($urandom) & 4'($urandom | 32'h5), 4'($urandom) & 4'($urandom),
                  ra, rb, 4'($urandom), $urandom_range(0, 63) == 0);
        end

        cycle(4'b0000, 4'b0000, '0, '0, '0, 1'b0);
        cycle(4'b0000, 4'b0000, '0, '0, '0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results still pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
